// File: rtl/int_ctrl_n.sv
// int_ctrl_n: N-channel external interrupt controller for a single-line CPU
// interrupt input. Fixed priority (lowest index wins), per-channel mask and
// level/edge mode, one interrupt in service at a time.
module int_ctrl_n #(
  parameter int               N_CH     = 8,
  parameter int               DATA_W   = 32,
  parameter logic [DATA_W-1:0] VEC_BASE = 'h10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   irq_src,
  output logic              int_req,
  output logic [DATA_W-1:0] int_num,
  input  logic              int_ack,
  input  logic              eoi,
  input  logic              reg_wr,
  input  logic [1:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t            state;
  logic [N_CH-1:0]   sync1, sync2, sync3;
  logic [N_CH-1:0]   mask, mode, pending, inservice;
  logic [CH_W-1:0]   ch_q, sel;
  logic              any_cand;
  logic [N_CH-1:0]   cand, rise, w1c, ack_clr, edge_nxt, pend_nxt;
  logic              ack_take;
  logic              unused_wdata;

  // Only the low N_CH write-data bits carry register state.
  assign unused_wdata = ^{1'b0, reg_wdata};

  assign cand     = pending & mask;
  assign rise     = sync2 & ~sync3;
  assign w1c      = (reg_wr && reg_addr == 2'd2) ? reg_wdata[N_CH-1:0] : '0;
  assign ack_take = (state == REQ) && int_ack;
  assign ack_clr  = ack_take ? (N_CH'(1) << ch_q) : '0;

  // Edge channels: a new edge beats any clear in the same cycle so it is
  // never lost. Level channels simply track the synchronised input, which
  // also gives the edge->level switch its live-level replacement.
  assign edge_nxt = (pending & ~w1c & ~ack_clr) | rise;
  assign pend_nxt = (mode & edge_nxt) | (~mode & sync2);

  // Fixed-priority pick: lowest candidate index.
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (cand[i]) sel = CH_W'(i);
    any_cand = |cand;
  end

  // Two-flop synchroniser plus a third flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Software-visible configuration and pending state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask    <= '0;
      mode    <= '0;
      pending <= '0;
    end else begin
      if (reg_wr && reg_addr == 2'd0) mask <= reg_wdata[N_CH-1:0];
      if (reg_wr && reg_addr == 2'd1) mode <= reg_wdata[N_CH-1:0];
      pending <= pend_nxt;
    end
  end

  // Request/service FSM with registered int_req/int_num/inservice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch_q      <= '0;
      int_req   <= 1'b0;
      int_num   <= '0;
      inservice <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            ch_q    <= sel;
            int_num <= VEC_BASE + DATA_W'(sel);
            int_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Ack wins over a same-cycle cancel; a higher-priority arrival
          // does not pre-empt what is already presented.
          if (int_ack) begin
            int_req   <= 1'b0;
            inservice <= ack_clr;
            state     <= SVC;
          end else if (!pending[ch_q] || !mask[ch_q]) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end
        end
        SVC: begin
          int_req <= 1'b0;
          if (eoi) begin
            inservice <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Combinational register read, zero-extended to DATA_W.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0:    reg_rdata[N_CH-1:0] = mask;
      2'd1:    reg_rdata[N_CH-1:0] = mode;
      2'd2:    reg_rdata[N_CH-1:0] = pending;
      default: reg_rdata[N_CH-1:0] = inservice;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl_n.sv
// tb_int_ctrl_n: scoreboard bench. Expected cause codes are queued when the
// stimulus is driven and compared when int_req rises.
module tb_int_ctrl_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_src = '0;
  logic        int_req;
  logic [31:0] int_num;
  logic        int_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        reg_wr = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];
  logic req_d = 1'b0;

  int_ctrl_n #(.N_CH(8), .DATA_W(32), .VEC_BASE(32'h10)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .int_req(int_req),
    .int_num(int_num), .int_ack(int_ack), .eoi(eoi), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: each rising int_req consumes one expected cause code.
  always @(negedge clk) begin
    if (int_req && !req_d) begin
      if (exp_q.size() > 0) chk("int_num", int_num, exp_q.pop_front());
      else                  chk("unexp_req", {31'b0, int_req}, 32'h0);
    end
    req_d <= int_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, e);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!int_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, int_req}, 32'h1);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic end_int();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic pulse(input int ch);
    irq_src[ch] = 1'b1;
    tick();
    irq_src[ch] = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_req", {31'b0, int_req}, 32'h0);
    chk("rst_num", int_num, 32'h0);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) rd("rst_reg", 2'(a), 32'h0);

    // Level channel 3: latency and re-request after eoi.
    wr(2'd0, 32'hFF);
    exp_q.push_back(32'h13);
    irq_src[3] = 1'b1;
    repeat (3) tick();
    chk("lat_pre", {31'b0, int_req}, 32'h0);
    tick();
    chk("lat_k3", {31'b0, int_req}, 32'h1);
    ack();
    chk("ack_req", {31'b0, int_req}, 32'h0);
    rd("insvc3", 2'd3, 32'h08);
    exp_q.push_back(32'h13);
    end_int();
    chk("eoi_gap", {31'b0, int_req}, 32'h0);
    tick();
    chk("re_req", {31'b0, int_req}, 32'h1);
    ack();
    irq_src[3] = 1'b0;
    repeat (4) tick();
    end_int();
    tick();

    // Priority: 2 beats 5, then 5 after service.
    exp_q.push_back(32'h12);
    exp_q.push_back(32'h15);
    irq_src[5] = 1'b1; irq_src[2] = 1'b1;
    wait_req("req_2");
    ack();
    irq_src[2] = 1'b0;
    repeat (4) tick();
    end_int();
    wait_req("req_5");
    ack();
    irq_src[5] = 1'b0;
    repeat (4) tick();
    end_int();
    tick();

    // Edge mode on channel 0.
    wr(2'd1, 32'h01);
    exp_q.push_back(32'h10);
    pulse(0);
    repeat (2) tick();
    rd("pend_edge", 2'd2, 32'h01);
    wait_req("req_edge");
    repeat (3) tick();
    rd("pend_hold", 2'd2, 32'h01);
    ack();
    rd("pend_ackclr", 2'd2, 32'h00);
    exp_q.push_back(32'h10);
    pulse(0);
    repeat (4) tick();
    rd("pend_svc", 2'd2, 32'h01);
    chk("svc_noreq", {31'b0, int_req}, 32'h0);
    end_int();
    wait_req("req_edge2");
    ack();
    end_int();
    tick();

    // Cancel by W1C on edge channel 4, then W1C racing int_ack.
    wr(2'd1, 32'h10);
    exp_q.push_back(32'h14);
    pulse(4);
    wait_req("req_c4");
    wr(2'd2, 32'h10);
    tick();
    chk("cancel_req", {31'b0, int_req}, 32'h0);
    rd("cancel_insvc", 2'd3, 32'h00);
    repeat (3) tick();
    chk("cancel_idle", {31'b0, int_req}, 32'h0);
    exp_q.push_back(32'h14);
    pulse(4);
    wait_req("req_c4b");
    int_ack = 1'b1;
    wr(2'd2, 32'h10);
    int_ack = 1'b0;
    rd("race_insvc", 2'd3, 32'h10);
    rd("race_pend", 2'd2, 32'h00);
    chk("race_req", {31'b0, int_req}, 32'h0);
    end_int();
    tick();

    // Masking.
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h00);
    irq_src = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("masked", {31'b0, int_req}, 32'h0);
    end
    rd("pend_all", 2'd2, 32'hFF);
    exp_q.push_back(32'h17);
    wr(2'd0, 32'h80);
    wait_req("req_7");
    tick();

    // Async reset while requesting.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, int_req}, 32'h0);
    chk("arst_num", int_num, 32'h0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rd("arst_reg", 2'(a), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst", {31'b0, int_req}, 32'h0);
    end
    chk("sb_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
